// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the ALU shift path: widths, sequencer states
// and the shift direction encoding.
`timescale 1ns/1ps
package kgp_alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = $clog2(DATA_W);

    // Step index counts down from the largest power-of-two stage to 1.
    localparam int STEP_W  = $clog2(SHAMT_W);
    localparam logic [STEP_W-1:0] K_START = STEP_W'(SHAMT_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// One combinational power-of-two shift stage with the control triplet
// (enable, dir, arith). A disabled stage passes its input through.
`timescale 1ns/1ps
module shift_stage
    import kgp_alu_pkg::*;
#(
    parameter int AMOUNT = 1
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              enable,
    input  logic              dir,
    input  logic              arith,
    output logic [DATA_W-1:0] data_out
);

    logic signed [DATA_W-1:0] data_signed;

    assign data_signed = data_in;

    // Select pass-through, left, logical right or sign-filling right shift.
    always_comb begin
        data_out = data_in;
        if (enable) begin
            if (dir == DIR_LEFT) begin
                data_out = data_in << AMOUNT;
            end else if (arith) begin
                data_out = DATA_W'(data_signed >>> AMOUNT);
            end else begin
                data_out = data_in >> AMOUNT;
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller. A request is applied as five fixed steps
// (16, 8, 4, 2, 1), one per clock, so latency never depends on the amount.
// Implementation choice: five shift_stage instances, each hard-wired to its
// own power-of-two amount and enabled by its latched shamt bit; the step
// index k picks which instance's output feeds the accumulator each cycle.
`timescale 1ns/1ps
module shift_sequencer
    import kgp_alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic               ready,
    output logic               done,
    output logic [DATA_W-1:0]  result
);

    state_t              state;
    logic [STEP_W-1:0]   k;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   acc_next;
    logic [SHAMT_W-1:0]  shamt_q;
    logic                dir_q;
    logic                arith_q;
    logic [DATA_W-1:0]   stage_out [SHAMT_W];

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        shift_stage #(
            .AMOUNT (1 << i)
        ) u_stage (
            .data_in  (acc),
            .enable   (shamt_q[i]),
            .dir      (dir_q),
            .arith    (arith_q),
            .data_out (stage_out[i])
        );
    end

    // Pick the output of the stage addressed by the current step index.
    always_comb begin
        acc_next = acc;
        if (k < STEP_W'(SHAMT_W)) begin
            acc_next = stage_out[k];
        end
    end

    // Sequencer FSM: accept in IDLE, step the accumulator in SHIFT, publish on k=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= K_START;
            acc     <= '0;
            shamt_q <= '0;
            dir_q   <= DIR_LEFT;
            arith_q <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= operand;
                        shamt_q <= shamt;
                        dir_q   <= dir;
                        // Sign fill is meaningless for left shifts.
                        arith_q <= arith & (dir == DIR_RIGHT);
                        k       <= K_START;
                        ready   <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    if (k == '0) begin
                        result <= acc_next;
                        done   <= 1'b1;
                        ready  <= 1'b1;
                        k      <= K_START;
                        state  <= IDLE;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: directed cases plus randomized requests
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        dir;
    logic        arith;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int total;
    int bad;

    shift_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .operand (operand),
        .shamt   (shamt),
        .dir     (dir),
        .arith   (arith),
        .ready   (ready),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the whole shift in one step with plain operators.
    function automatic logic [31:0] model(input logic [31:0] op, input logic [4:0] sh,
                                          input logic d, input logic a);
        logic signed [31:0] s;
        s = op;
        if (!d) return op << sh;
        if (a) return s >>> sh;
        return op >> sh;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request, optionally poke start while busy, and check the outcome.
    task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] sh,
                          input logic d, input logic a, input logic ign);
        logic [31:0] exp;
        int cyc;
        exp = model(op, sh, d, a);
        @(negedge clk);
        check({tag, "_ready"}, {31'b0, ready}, 32'd1);
        operand = op; shamt = sh; dir = d; arith = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        operand = $urandom; shamt = 5'($urandom); dir = 1'($urandom); arith = 1'($urandom);
        cyc = 0;
        while (!done && cyc < 12) begin
            if (ign && cyc == 1) begin
                start = 1'b1;
                operand = ~op;
                shamt = ~sh;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'd5);
        check({tag, "_result"}, result, exp);
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int pushed;
        int got_cnt;
        int cyc;
        int last_done;
        logic [31:0] expq[$];
        logic [31:0] op;
        logic [4:0]  sh;
        logic        d;
        logic        a;

        total = 0;
        bad = 0;
        rst_n = 1'b0; start = 1'b0; operand = '0; shamt = '0; dir = 1'b0; arith = 1'b0;

        // Reset and idle behaviour
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("idle_no_done", 32'(n_done), 32'd0);
        check("idle_result", result, 32'd0);

        // Directed cases
        run_op("sll4",      32'h0000_00F1, 5'd4,  1'b0, 1'b0, 1'b0);
        check("sll4_value", result, 32'h0000_0F10);
        run_op("srl4",      32'h8000_0010, 5'd4,  1'b1, 1'b0, 1'b0);
        check("srl4_value", result, 32'h0800_0001);
        run_op("sra4",      32'h8000_0010, 5'd4,  1'b1, 1'b1, 1'b0);
        check("sra4_value", result, 32'hF800_0001);
        run_op("sra31",     32'h8000_0010, 5'd31, 1'b1, 1'b1, 1'b0);
        check("sra31_value", result, 32'hFFFF_FFFF);
        run_op("zero",      32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 1'b0);
        check("zero_value", result, 32'hDEAD_BEEF);
        run_op("sll31",     32'h0000_0001, 5'd31, 1'b0, 1'b0, 1'b0);
        check("sll31_value", result, 32'h8000_0000);
        run_op("left_arith", 32'h8000_0003, 5'd3, 1'b0, 1'b1, 1'b0);
        check("left_arith_value", result, 32'h0000_0018);
        run_op("ignored",   32'h1234_5678, 5'd7,  1'b1, 1'b0, 1'b1);

        // Start held high: three back-to-back requests
        pushed = 0; got_cnt = 0; cyc = 0; last_done = -1;
        while (got_cnt < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (expq.size() > 0) check("b2b_result", result, expq.pop_front());
                else check("b2b_extra_done", 32'd1, 32'd0);
                if (last_done >= 0) check("b2b_spacing", 32'(cyc - last_done), 32'd6);
                last_done = cyc;
                got_cnt++;
            end
            if (pushed == 3) begin
                start = 1'b0;
            end else if (ready) begin
                op = $urandom; sh = 5'($urandom); d = 1'($urandom); a = 1'($urandom);
                operand = op; shamt = sh; dir = d; arith = a; start = 1'b1;
                expq.push_back(model(op, sh, d, a));
                pushed++;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(got_cnt), 32'd3);

        // Reset in the middle of an operation
        @(negedge clk);
        operand = 32'hCAFE_F00D; shamt = 5'd9; dir = 1'b1; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_result_after", result, 32'd0);
        run_op("after_rst", 32'h0F0F_0F0F, 5'd1, 1'b0, 1'b0, 1'b0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            run_op("rand", $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
